// File: rtl/checkout_lane_ctrl_pkg.sv
// Shared types and constants for the checkout lane slice.
package store_pkg;

   localparam int UPC_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      ALARM,
      DONE
   } lane_state_t;

endpackage

// File: rtl/checkout_lane_ctrl_if.sv
// Scanner-to-lane handshake plus customer/manager control pulses.
interface checkout_lane_ctrl_if;
   import store_pkg::*;

   logic [UPC_W-1:0] upc;
   logic             scan_valid;
   logic             scan_ready;
   logic             pay;
   logic             clear;

   modport master (
      output upc,
      output scan_valid,
      output pay,
      output clear,
      input  scan_ready
   );

   modport slave (
      input  upc,
      input  scan_valid,
      input  pay,
      input  clear,
      output scan_ready
   );

endinterface

// File: rtl/checkout_lane_ctrl_upc_decode.sv
// Combinational UPC classifier: flags stolen and discounted items.
module upc_decode
   import store_pkg::*;
(
   input  logic [UPC_W-1:0] upc,
   output logic             stolen,
   output logic             disc
);

   // Sum-of-products decode of the 4-bit code.
   always_comb begin
      stolen = (upc[0] & ~upc[1] & ~upc[3]) | (~upc[0] & ~upc[2] & ~upc[3]);
      disc   = upc[1] | (upc[0] & upc[2]);
   end

endmodule

// File: rtl/checkout_lane_ctrl.sv
// Checkout lane sequencer: accepts scans, counts items/discounts,
// latches the stolen-item alarm and freezes counts on pay.
module checkout_lane_ctrl
   import store_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   checkout_lane_ctrl_if.slave   lane,
   output logic                  alarm,
   output logic                  done,
   output logic                  last_disc,
   output logic [CNT_W-1:0]      item_count,
   output logic [CNT_W-1:0]      disc_count
);

   lane_state_t state;
   logic        stolen;
   logic        disc;
   logic        sat;
   logic        accept;

   upc_decode u_decode (
      .upc    (lane.upc),
      .stolen (stolen),
      .disc   (disc)
   );

   // Ready only while collecting items and the item counter has headroom.
   always_comb begin
      sat             = (item_count == '1);
      lane.scan_ready = ((state == IDLE) || (state == OPEN)) && !sat;
      accept          = lane.scan_valid && lane.scan_ready;
   end

   // Lane FSM with item/discount counters and latched status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         alarm      <= 1'b0;
         done       <= 1'b0;
         last_disc  <= 1'b0;
         item_count <= '0;
         disc_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (stolen) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end else begin
                     state      <= OPEN;
                     item_count <= CNT_W'(1);
                     disc_count <= CNT_W'(disc);
                     last_disc  <= disc;
                  end
               end
            end
            OPEN: begin
               // clear beats a same-cycle scan; a scan beats a same-cycle pay
               if (lane.clear) begin
                  state      <= IDLE;
                  item_count <= '0;
                  disc_count <= '0;
                  last_disc  <= 1'b0;
               end else if (accept) begin
                  if (stolen) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end else begin
                     item_count <= item_count + CNT_W'(1);
                     disc_count <= disc_count + CNT_W'(disc);
                     last_disc  <= disc;
                  end
               end else if (lane.pay) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            ALARM: begin
               if (lane.clear) begin
                  alarm <= 1'b0;
                  state <= (item_count != '0) ? OPEN : IDLE;
               end
            end
            DONE: begin
               if (lane.clear) begin
                  state      <= IDLE;
                  done       <= 1'b0;
                  item_count <= '0;
                  disc_count <= '0;
                  last_disc  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_checkout_lane_ctrl.sv
// Self-checking bench for checkout_lane_ctrl (CNT_W = 2 so saturation is reachable).
module tb_checkout_lane_ctrl;

   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic             alarm;
   logic             done;
   logic             last_disc;
   logic [CNT_W-1:0] item_count;
   logic [CNT_W-1:0] disc_count;

   checkout_lane_ctrl_if lif ();

   checkout_lane_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .lane       (lif),
      .alarm      (alarm),
      .done       (done),
      .last_disc  (last_disc),
      .item_count (item_count),
      .disc_count (disc_count)
   );

   always #5 clk = ~clk;

   // Classification tables by UPC value: stolen = {0,1,2,5},
   // discounted = {2,3,5,6,7,10,11,13,14,15}.
   bit [15:0] stolen_tab = 16'b0000_0000_0010_0111;
   bit [15:0] disc_tab   = 16'b1110_1100_1110_1100;

   int checks = 0;
   int errors = 0;

   // Model: the lane phase is implied by the flags and the item count.
   int m_items = 0;
   int m_disc  = 0;
   bit m_last  = 1'b0;
   bit m_alarm = 1'b0;
   bit m_done  = 1'b0;

   function automatic bit m_ready();
      return !m_alarm && !m_done && (m_items != MAXC);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_items = 0; m_disc = 0; m_last = 1'b0; m_alarm = 1'b0; m_done = 1'b0;
      end else begin
         bit acc, st, ds;
         acc = lif.scan_valid && m_ready();
         st  = stolen_tab[lif.upc];
         ds  = disc_tab[lif.upc];
         if (m_alarm) begin
            if (lif.clear) m_alarm = 1'b0;
         end else if (m_done) begin
            if (lif.clear) begin
               m_done = 1'b0; m_items = 0; m_disc = 0; m_last = 1'b0;
            end
         end else if (m_items == 0) begin
            if (acc) begin
               if (st) m_alarm = 1'b1;
               else begin
                  m_items = 1; m_disc = int'(ds); m_last = ds;
               end
            end
         end else begin
            if (lif.clear) begin
               m_items = 0; m_disc = 0; m_last = 1'b0;
            end else if (acc) begin
               if (st) m_alarm = 1'b1;
               else begin
                  m_items++; m_disc += int'(ds); m_last = ds;
               end
            end else if (lif.pay) m_done = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always begin
      @(negedge clk);
      #1;
      chk("alarm",      int'(alarm),          int'(m_alarm));
      chk("done",       int'(done),           int'(m_done));
      chk("last_disc",  int'(last_disc),      int'(m_last));
      chk("item_count", int'(item_count),     m_items);
      chk("disc_count", int'(disc_count),     m_disc);
      chk("scan_ready", int'(lif.scan_ready), int'(m_ready()));
   end

   task automatic cyc(input logic [3:0] u, input logic v, input logic p, input logic c);
      lif.upc        = u;
      lif.scan_valid = v;
      lif.pay        = p;
      lif.clear      = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      lif.upc = '0; lif.scan_valid = 1'b0; lif.pay = 1'b0; lif.clear = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_alarm", int'(alarm), 0);
      chk("rst_items", int'(item_count), 0);
      chk("rst_ready", int'(lif.scan_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: three items, two discounted, then pay
      cyc(4'b0110, 1, 0, 0);
      chk("t1_last", int'(last_disc), 1);
      cyc(4'b1000, 1, 0, 0);
      chk("t1_last2", int'(last_disc), 0);
      cyc(4'b1101, 1, 0, 0);
      cyc(4'b0000, 0, 1, 0);
      chk("t1_items", int'(item_count), 3);
      chk("t1_disc",  int'(disc_count), 2);
      chk("t1_done",  int'(done), 1);
      chk("t1_ready", int'(lif.scan_ready), 0);
      cyc(4'b0000, 0, 0, 1);
      chk("t1_clr_items", int'(item_count), 0);

      // 2: stolen item mid-transaction
      cyc(4'b0110, 1, 0, 0);
      cyc(4'b0001, 1, 0, 0);
      chk("t2_alarm", int'(alarm), 1);
      chk("t2_items", int'(item_count), 1);
      chk("t2_ready", int'(lif.scan_ready), 0);
      cyc(4'b0000, 0, 1, 0);
      chk("t2_pay_ign", int'(done), 0);
      cyc(4'b0000, 0, 0, 1);
      chk("t2_clr_alarm", int'(alarm), 0);
      chk("t2_clr_items", int'(item_count), 1);
      chk("t2_clr_ready", int'(lif.scan_ready), 1);
      cyc(4'b0000, 0, 0, 1);

      // 3: stolen item from idle
      cyc(4'b0000, 1, 0, 0);
      chk("t3_alarm", int'(alarm), 1);
      chk("t3_items", int'(item_count), 0);
      cyc(4'b0000, 0, 0, 1);
      chk("t3_ready", int'(lif.scan_ready), 1);
      cyc(4'b0000, 0, 1, 0);
      chk("t3_idle_pay", int'(done), 0);

      // 4: saturation
      repeat (3) cyc(4'b1000, 1, 0, 0);
      chk("t4_items", int'(item_count), 3);
      chk("t4_ready", int'(lif.scan_ready), 0);
      cyc(4'b1000, 1, 0, 0);
      chk("t4_held", int'(item_count), 3);
      cyc(4'b0000, 0, 1, 0);
      chk("t4_done", int'(done), 1);
      cyc(4'b0000, 0, 0, 1);

      // 5: scan and pay in the same cycle
      cyc(4'b0110, 1, 0, 0);
      cyc(4'b1010, 1, 1, 0);
      chk("t5_items", int'(item_count), 2);
      chk("t5_disc",  int'(disc_count), 2);
      chk("t5_open",  int'(done), 0);
      cyc(4'b0000, 0, 1, 0);
      chk("t5_done", int'(done), 1);
      cyc(4'b0000, 0, 0, 1);

      // 6: async reset mid-transaction
      cyc(4'b0110, 1, 0, 0);
      cyc(4'b1000, 1, 0, 0);
      chk("t6_items", int'(item_count), 2);
      lif.scan_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_items0", int'(item_count), 0);
      chk("t6_disc0",  int'(disc_count), 0);
      chk("t6_last0",  int'(last_disc), 0);
      chk("t6_ready",  int'(lif.scan_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
         cyc(4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0));
      end
      cyc(4'b0000, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
